// File: rtl/dsiq_sample_fifo.sv
// Downstream TX sample assembler: packs IQ bytes into 32-bit words, buffers them in a
// first-word-fall-through FIFO and plays them out once primed, with error counters.
module dsiq_sample_fifo #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned PRIME_LEVEL = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_tdata,
    input  logic                  in_tvalid,
    input  logic                  in_tlast,
    input  logic                  in_tuser,
    input  logic                  flush,
    output logic [31:0]           out_tdata,
    output logic [2:0]            out_tuser,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           frame_err_cnt,
    output logic [15:0]           underflow_cnt
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DepthLvl = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [DEPTH_LOG2:0] PrimeLvl = (DEPTH_LOG2 + 1)'(PRIME_LEVEL);

    typedef enum logic {StPrime, StRun} state_e;

    logic [1:0]            bi_q;
    logic [7:0]            i_hi_q, i_lo_q, q_hi_q;
    logic [2:0]            user_q;
    logic                  asm_valid_q;
    logic [31:0]           asm_word_q;
    logic [2:0]            asm_user_q;

    logic [34:0]           mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q, level_d, level_after_pop;
    state_e                state_q;
    logic                  out_tvalid_q;
    logic                  overflow_q;
    logic [15:0]           drop_cnt_q, frame_err_cnt_q, underflow_cnt_q;

    logic pop, full, wr, drop, frame_err, underflow;
    logic [34:0] head;

    // Framing error whenever tlast disagrees with reaching the fourth byte.
    assign frame_err = in_tvalid && !flush && (in_tlast != (bi_q == 2'd3));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bi_q        <= 2'd0;
            i_hi_q      <= 8'h00;
            i_lo_q      <= 8'h00;
            q_hi_q      <= 8'h00;
            user_q      <= 3'b000;
            asm_valid_q <= 1'b0;
            asm_word_q  <= 32'h0;
            asm_user_q  <= 3'b000;
        end else begin
            asm_valid_q <= 1'b0;
            if (flush) begin
                bi_q <= 2'd0;
            end else if (in_tvalid) begin
                unique case (bi_q)
                    2'd0: begin
                        i_hi_q    <= in_tdata;
                        user_q[0] <= in_tuser;
                    end
                    2'd1: begin
                        i_lo_q    <= in_tdata;
                        user_q[1] <= in_tuser;
                    end
                    2'd2: begin
                        q_hi_q    <= in_tdata;
                        user_q[2] <= in_tuser;
                    end
                    2'd3: begin
                        if (in_tlast) begin
                            asm_valid_q <= 1'b1;
                            asm_word_q  <= {i_hi_q, i_lo_q, q_hi_q, in_tdata};
                            asm_user_q  <= user_q;
                        end
                    end
                endcase
                if (in_tlast || bi_q == 2'd3) begin
                    bi_q <= 2'd0;
                end else begin
                    bi_q <= bi_q + 2'd1;
                end
            end
        end
    end

    assign pop  = out_tvalid_q && out_tready;
    assign full = (level_q == DepthLvl);
    assign wr   = asm_valid_q && !flush && (!full || pop);
    assign drop = asm_valid_q && !flush && full && !pop;
    // A word written this cycle is not yet visible, so it masks an underflow.
    assign underflow = (state_q == StRun) && out_tready && (level_q == '0) && !wr && !flush;

    always_comb begin
        level_after_pop = level_q - {{DEPTH_LOG2{1'b0}}, pop};
        level_d         = level_after_pop + {{DEPTH_LOG2{1'b0}}, wr};
        if (flush) begin
            level_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= {asm_user_q, asm_word_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    // Output FSM; in RUN a freshly written word becomes valid one cycle after its write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StPrime;
            out_tvalid_q <= 1'b0;
        end else if (flush) begin
            state_q      <= StPrime;
            out_tvalid_q <= 1'b0;
        end else begin
            case (state_q)
                StPrime: begin
                    if (level_d >= PrimeLvl) begin
                        state_q      <= StRun;
                        out_tvalid_q <= 1'b1;
                    end else begin
                        out_tvalid_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (underflow) begin
                        state_q      <= StPrime;
                        out_tvalid_q <= 1'b0;
                    end else begin
                        out_tvalid_q <= (level_after_pop != '0);
                    end
                end
                default: begin
                    state_q      <= StPrime;
                    out_tvalid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q      <= 1'b0;
            drop_cnt_q      <= 16'h0;
            frame_err_cnt_q <= 16'h0;
            underflow_cnt_q <= 16'h0;
        end else begin
            if (flush) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
            if (drop && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (frame_err && frame_err_cnt_q != 16'hFFFF) begin
                frame_err_cnt_q <= frame_err_cnt_q + 16'd1;
            end
            if (underflow && underflow_cnt_q != 16'hFFFF) begin
                underflow_cnt_q <= underflow_cnt_q + 16'd1;
            end
        end
    end

    // Head is forced to zero when empty so stale or unwritten storage never shows.
    assign head          = (level_q != '0) ? mem_q[rd_ptr_q] : 35'h0;
    assign out_tdata     = head[31:0];
    assign out_tuser     = head[34:32];
    assign out_tvalid    = out_tvalid_q;
    assign level         = level_q;
    assign overflow      = overflow_q;
    assign drop_cnt      = drop_cnt_q;
    assign frame_err_cnt = frame_err_cnt_q;
    assign underflow_cnt = underflow_cnt_q;

endmodule

// File: tb/tb_dsiq_sample_fifo.sv
// Bench for dsiq_sample_fifo: instance a (4 deep, prime 1) covers packing, framing, overflow,
// flush and reset; instance b (8 deep, prime 4) covers priming and underflow.
module tb_dsiq_sample_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_tdata = 8'h00;
    logic        in_tvalid = 1'b0;
    logic        in_tlast = 1'b0;
    logic        in_tuser = 1'b0;
    logic        flush = 1'b0;
    logic        ready_a = 1'b0;
    logic        ready_b = 1'b0;

    logic [31:0] tdata_a, tdata_b;
    logic [2:0]  tuser_a, tuser_b;
    logic        tvalid_a, tvalid_b;
    logic [2:0]  level_a;
    logic [3:0]  level_b;
    logic        ovf_a, ovf_b;
    logic [15:0] drop_a, drop_b, ferr_a, ferr_b, und_a, und_b;

    int checks = 0;
    int failures = 0;
    logic [34:0] q_a[$];
    logic [34:0] q_b[$];

    always #5 clk = ~clk;

    dsiq_sample_fifo #(.DEPTH_LOG2(2), .PRIME_LEVEL(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
        .in_tlast(in_tlast), .in_tuser(in_tuser), .flush(flush), .out_tdata(tdata_a),
        .out_tuser(tuser_a), .out_tvalid(tvalid_a), .out_tready(ready_a), .level(level_a),
        .overflow(ovf_a), .drop_cnt(drop_a), .frame_err_cnt(ferr_a), .underflow_cnt(und_a)
    );

    dsiq_sample_fifo #(.DEPTH_LOG2(3), .PRIME_LEVEL(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
        .in_tlast(in_tlast), .in_tuser(in_tuser), .flush(flush), .out_tdata(tdata_b),
        .out_tuser(tuser_b), .out_tvalid(tvalid_b), .out_tready(ready_b), .level(level_b),
        .overflow(ovf_b), .drop_cnt(drop_b), .frame_err_cnt(ferr_b), .underflow_cnt(und_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every accepted output word is compared with the queue head.
    always @(negedge clk) begin
        if (rst_n && tvalid_a && ready_a) begin
            if (q_a.size() == 0) begin
                check("sb_a_unexpected_word", {29'h0, tuser_a, tdata_a}, 64'hDEAD);
            end else begin
                logic [34:0] exp_a;
                exp_a = q_a.pop_front();
                check("sb_a_word", {29'h0, tuser_a, tdata_a}, {29'h0, exp_a});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && tvalid_b && ready_b) begin
            if (q_b.size() == 0) begin
                check("sb_b_unexpected_word", {29'h0, tuser_b, tdata_b}, 64'hDEAD);
            end else begin
                logic [34:0] exp_b;
                exp_b = q_b.pop_front();
                check("sb_b_word", {29'h0, tuser_b, tdata_b}, {29'h0, exp_b});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
        in_tdata  = d;
        in_tlast  = l;
        in_tuser  = u;
        in_tvalid = 1'b1;
        tick();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        in_tuser  = 1'b0;
    endtask

    task automatic send_sample(input logic [31:0] w, input logic [2:0] u);
        send_byte(w[31:24], 1'b0, u[0]);
        send_byte(w[23:16], 1'b0, u[1]);
        send_byte(w[15:8], 1'b0, u[2]);
        send_byte(w[7:0], 1'b1, 1'b0);
    endtask

    task automatic pop_a_once();
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_tvalid", tvalid_a, 0);
        check("rst_tdata", tdata_a, 0);
        check("rst_level", level_a, 0);
        check("rst_counters", {drop_a, ferr_a, und_a, 15'h0, ovf_a}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic packing
        send_sample(32'h12345678, 3'b101);
        tick();
        check("pack_level", level_a, 1);
        check("pack_tvalid", tvalid_a, 1);
        check("pack_tdata", tdata_a, 32'h12345678);
        check("pack_tuser", tuser_a, 3'b101);
        q_a.push_back({3'b101, 32'h12345678});
        pop_a_once();
        check("pack_drained_level", level_a, 0);
        check("pack_drained_tvalid", tvalid_a, 0);

        // Framing
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b1, 1'b0);
        check("frame_early_last", ferr_a, 1);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h05, 1'b1, 1'b0);
        tick();
        check("frame_five_byte_adds_two", ferr_a, 3);
        check("frame_nothing_written", level_a, 0);
        send_sample(32'hA1B2C3D4, 3'b010);
        tick();
        tick();
        check("frame_recover_tvalid", tvalid_a, 1);
        check("frame_recover_level", level_a, 1);
        q_a.push_back({3'b010, 32'hA1B2C3D4});
        pop_a_once();

        // Overflow
        for (int i = 1; i <= 6; i++) begin
            send_sample(32'hC000_0000 | 32'(i), 3'(i));
            if (i <= 4) q_a.push_back({3'(i), 32'hC000_0000 | 32'(i)});
        end
        tick();
        tick();
        check("ovf_level", level_a, 4);
        check("ovf_drop_cnt", drop_a, 2);
        check("ovf_flag", ovf_a, 1);
        send_sample(32'hC0000007, 3'b111);
        pop_a_once();
        check("ovf_write_with_pop_level", level_a, 4);
        check("ovf_write_with_pop_drop", drop_a, 2);
        q_a.push_back({3'b111, 32'hC0000007});

        // Flush during the second byte of a sample
        pop_a_once();
        check("flush_pre_level", level_a, 3);
        send_byte(8'h11, 1'b0, 1'b1);
        flush = 1'b1;
        send_byte(8'h22, 1'b0, 1'b0);
        flush = 1'b0;
        q_a.delete();
        check("flush_level", level_a, 0);
        check("flush_overflow", ovf_a, 0);
        check("flush_tvalid", tvalid_a, 0);
        check("flush_counters", {drop_a, ferr_a, und_a}, {16'd2, 16'd3, 16'd0});
        send_sample(32'h0BADF00D, 3'b110);
        tick();
        check("flush_next_level", level_a, 1);
        check("flush_primed_tvalid", tvalid_a, 1);
        check("flush_next_tdata", tdata_a, 32'h0BADF00D);
        check("flush_no_frame_err", ferr_a, 3);
        q_a.push_back({3'b110, 32'h0BADF00D});
        pop_a_once();

        // Asynchronous reset mid-sample with words queued
        send_sample(32'hD0D00001, 3'b001);
        send_sample(32'hD0D00002, 3'b010);
        tick();
        tick();
        q_a.push_back({3'b001, 32'hD0D00001});
        pop_a_once();
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", tvalid_a, 0);
        check("arst_tdata", {tuser_a, tdata_a}, 0);
        check("arst_level", level_a, 0);
        check("arst_counters", {drop_a, ferr_a, und_a, 15'h0, ovf_a}, 0);
        q_a.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_sample(32'hE1E2E3E4, 3'b011);
        tick();
        check("arst_restart_tdata", tdata_a, 32'hE1E2E3E4);
        check("arst_restart_ferr", ferr_a, 0);
        q_a.push_back({3'b011, 32'hE1E2E3E4});
        pop_a_once();

        // Priming and underflow on instance b
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            send_sample(32'hB000_0000 | 32'(i), 3'(i));
            tick();
            tick();
            check("prime_hold_tvalid", tvalid_b, 0);
        end
        check("prime_level3", level_b, 3);
        send_sample(32'hB0000004, 3'b100);
        tick();
        check("prime_level4", level_b, 4);
        check("prime_tvalid_up", tvalid_b, 1);
        for (int i = 1; i <= 4; i++) q_b.push_back({3'(i), 32'hB000_0000 | 32'(i)});
        ready_b = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        ready_b = 1'b0;
        check("underflow_cnt", und_b, 1);
        check("underflow_tvalid", tvalid_b, 0);
        check("underflow_level", level_b, 0);
        send_sample(32'hB0000005, 3'b000);
        tick();
        tick();
        tick();
        check("underflow_reprime_level", level_b, 1);
        check("underflow_reprime_tvalid", tvalid_b, 0);

        check("sb_a_drained", q_a.size(), 0);
        check("sb_b_drained", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
